// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared types, widths and bus encodings for the dcache miss handler
package dcache_pkg;

    localparam int DCACHE_TAG_W     = 8;
    localparam int DCACHE_IDX_W     = 5;
    localparam int MSHR_NUM_DEFAULT = 4;
    localparam int LQ_IDX_W_DEFAULT = 3;
    localparam int MEM_TAG_W        = 4;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'd0,
        BUS_LOAD  = 2'd1,
        BUS_STORE = 2'd2
    } bus_cmd_e;

    typedef enum logic [1:0] {
        MSHR_EMPTY     = 2'd0,
        MSHR_WAIT_ISS  = 2'd1,
        MSHR_WAIT_MEM  = 2'd2,
        MSHR_WAIT_FILL = 2'd3
    } mshr_state_e;

    typedef struct packed {
        mshr_state_e                 state;
        logic                        is_st;
        logic [DCACHE_TAG_W-1:0]     tag;
        logic [DCACHE_IDX_W-1:0]     idx;
        logic [63:0]                 data;
        logic [MEM_TAG_W-1:0]        mem_tag;
        logic [LQ_IDX_W_DEFAULT-1:0] lq_idx;
    } mshr_entry_t;

    // Byte address of a cache block: {zero, tag, idx, 3'b000}
    function automatic logic [63:0] blk_addr(input logic [DCACHE_TAG_W-1:0] tag,
                                             input logic [DCACHE_IDX_W-1:0] idx);
        logic [63:0] a;
        a = '0;
        a[DCACHE_IDX_W+2:3] = idx;
        a[DCACHE_TAG_W+DCACHE_IDX_W+2:DCACHE_IDX_W+3] = tag;
        return a;
    endfunction

endpackage

// File: rtl/dcache_mshr_pe.sv
// rtl/dcache_mshr_pe.sv - lowest-index priority encoder
module dcache_mshr_pe #(
    parameter int WIDTH = 4,
    parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] req_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             vld_o
);

    // Scan from the top down so the lowest set bit is the last (winning) assignment
    always_comb begin
        idx_o = '0;
        vld_o = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = IDX_W'(i);
                vld_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dcache_mshr_ctrl.sv
// rtl/dcache_mshr_ctrl.sv - dcache miss status holding registers; DCACHE_MSHR_FWD_EN forwards load data at completion
module dcache_mshr_ctrl
    import dcache_pkg::*;
#(
    parameter int MSHR_NUM = MSHR_NUM_DEFAULT,
    parameter int LQ_IDX_W = LQ_IDX_W_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_vld_i,
    output logic                    req_rdy_o,
    input  logic                    req_is_st_i,
    input  logic [DCACHE_TAG_W-1:0] req_tag_i,
    input  logic [DCACHE_IDX_W-1:0] req_idx_i,
    input  logic [63:0]             req_data_i,
    input  logic [LQ_IDX_W-1:0]     req_lq_idx_i,
    output logic [1:0]              proc2mem_command_o,
    output logic [63:0]             proc2mem_addr_o,
    output logic [63:0]             proc2mem_data_o,
    input  logic [3:0]              mem2proc_response_i,
    input  logic [3:0]              mem2proc_tag_i,
    input  logic [63:0]             mem2proc_data_i,
    output logic                    mshr_rsp_wr_en_o,
    output logic [DCACHE_TAG_W-1:0] mshr_rsp_wr_tag_o,
    output logic [DCACHE_IDX_W-1:0] mshr_rsp_wr_idx_o,
    output logic [63:0]             mshr_rsp_wr_data_o,
    input  logic                    mshr_rsp_wr_dty_i,
    output logic                    mshr_iss_st_en_o,
    output logic [DCACHE_TAG_W-1:0] mshr_iss_st_tag_o,
    output logic [DCACHE_IDX_W-1:0] mshr_iss_st_idx_o,
    output logic [63:0]             mshr_iss_st_data_o,
    input  logic                    mshr_iss_dty_i,
    output logic                    mshr_evict_en_o,
    output logic [DCACHE_IDX_W-1:0] mshr_evict_idx_o,
    input  logic [DCACHE_TAG_W-1:0] mshr_evict_tag_i,
    input  logic [63:0]             mshr_evict_data_i,
    output logic                    ld_rsp_vld_o,
    output logic [LQ_IDX_W-1:0]     ld_rsp_lq_idx_o,
    output logic [63:0]             ld_rsp_data_o
);

    localparam int MSHR_IDX_W = (MSHR_NUM > 1) ? $clog2(MSHR_NUM) : 1;

    mshr_entry_t ent_q [MSHR_NUM];
    mshr_entry_t ent_d [MSHR_NUM];

    logic [MSHR_NUM-1:0]   empty_vec, iss_vec, fill_vec;
    logic                  dup_hit;
    logic [MSHR_IDX_W-1:0] alloc_idx, iss_idx, fill_idx;
    logic                  alloc_vld, iss_vld, fill_vld;
    logic                  fill_dty, bus_busy, cpl_hit;
    mshr_entry_t           fill_ent, iss_ent;

    // Per-entry state decode and secondary-miss detection against the incoming request
    always_comb begin
        empty_vec = '0;
        iss_vec   = '0;
        fill_vec  = '0;
        dup_hit   = 1'b0;
        for (int i = 0; i < MSHR_NUM; i++) begin
            empty_vec[i] = (ent_q[i].state == MSHR_EMPTY);
            iss_vec[i]   = (ent_q[i].state == MSHR_WAIT_ISS);
            fill_vec[i]  = (ent_q[i].state == MSHR_WAIT_FILL);
            if (ent_q[i].state != MSHR_EMPTY && ent_q[i].tag == req_tag_i && ent_q[i].idx == req_idx_i)
                dup_hit = 1'b1;
        end
    end

    dcache_mshr_pe #(.WIDTH(MSHR_NUM), .IDX_W(MSHR_IDX_W)) u_pe_alloc (
        .req_i(empty_vec), .idx_o(alloc_idx), .vld_o(alloc_vld));
    dcache_mshr_pe #(.WIDTH(MSHR_NUM), .IDX_W(MSHR_IDX_W)) u_pe_iss (
        .req_i(iss_vec), .idx_o(iss_idx), .vld_o(iss_vld));
    dcache_mshr_pe #(.WIDTH(MSHR_NUM), .IDX_W(MSHR_IDX_W)) u_pe_fill (
        .req_i(fill_vec), .idx_o(fill_idx), .vld_o(fill_vld));

    // Next-entry state and all outputs: fill/writeback first (it owns the bus), then issue, completion, allocate
    always_comb begin
        ent_d              = ent_q;
        req_rdy_o          = 1'b0;
        proc2mem_command_o = BUS_NONE;
        proc2mem_addr_o    = '0;
        proc2mem_data_o    = '0;
        mshr_rsp_wr_en_o   = 1'b0;
        mshr_rsp_wr_tag_o  = '0;
        mshr_rsp_wr_idx_o  = '0;
        mshr_rsp_wr_data_o = '0;
        mshr_iss_st_en_o   = 1'b0;
        mshr_iss_st_tag_o  = '0;
        mshr_iss_st_idx_o  = '0;
        mshr_iss_st_data_o = '0;
        mshr_evict_en_o    = 1'b0;
        mshr_evict_idx_o   = '0;
        ld_rsp_vld_o       = 1'b0;
        ld_rsp_lq_idx_o    = '0;
        ld_rsp_data_o      = '0;
        bus_busy           = 1'b0;
        fill_dty           = 1'b0;
        cpl_hit            = 1'b0;
        fill_ent           = ent_q[fill_idx];
        iss_ent            = ent_q[iss_idx];

        // Outputs stay quiet while reset is held so nothing leaks from pre-reset state
        if (!rst) begin
            req_rdy_o = alloc_vld && !dup_hit;

            if (fill_vld) begin
                // The cache reports victim dirtiness for whichever port we present the block on
                if (fill_ent.is_st) begin
                    mshr_iss_st_tag_o  = fill_ent.tag;
                    mshr_iss_st_idx_o  = fill_ent.idx;
                    mshr_iss_st_data_o = fill_ent.data;
                    fill_dty           = mshr_iss_dty_i;
                end else begin
                    mshr_rsp_wr_tag_o  = fill_ent.tag;
                    mshr_rsp_wr_idx_o  = fill_ent.idx;
                    mshr_rsp_wr_data_o = fill_ent.data;
                    fill_dty           = mshr_rsp_wr_dty_i;
                end
                if (fill_dty) begin
                    bus_busy           = 1'b1;
                    proc2mem_command_o = BUS_STORE;
                    proc2mem_addr_o    = blk_addr(mshr_evict_tag_i, fill_ent.idx);
                    proc2mem_data_o    = mshr_evict_data_i;
                    if (mem2proc_response_i != '0) begin
                        mshr_evict_en_o  = 1'b1;
                        mshr_evict_idx_o = fill_ent.idx;
                    end
                end else begin
                    if (fill_ent.is_st) begin
                        mshr_iss_st_en_o = 1'b1;
                    end else begin
                        mshr_rsp_wr_en_o = 1'b1;
`ifndef DCACHE_MSHR_FWD_EN
                        ld_rsp_vld_o    = 1'b1;
                        ld_rsp_lq_idx_o = fill_ent.lq_idx;
                        ld_rsp_data_o   = fill_ent.data;
`endif
                    end
                    ent_d[fill_idx].state = MSHR_EMPTY;
                end
            end

            if (iss_vld && !bus_busy) begin
                proc2mem_command_o = BUS_LOAD;
                proc2mem_addr_o    = blk_addr(iss_ent.tag, iss_ent.idx);
                if (mem2proc_response_i != '0) begin
                    ent_d[iss_idx].mem_tag = mem2proc_response_i;
                    ent_d[iss_idx].state   = MSHR_WAIT_MEM;
                end
            end

            // Tags not held by any waiting entry (e.g. issued before a reset) are simply dropped
            if (mem2proc_tag_i != '0) begin
                for (int i = 0; i < MSHR_NUM; i++) begin
                    if (!cpl_hit && ent_q[i].state == MSHR_WAIT_MEM && ent_q[i].mem_tag == mem2proc_tag_i) begin
                        cpl_hit            = 1'b1;
                        ent_d[i].data      = mem2proc_data_i;
                        ent_d[i].state     = MSHR_WAIT_FILL;
`ifdef DCACHE_MSHR_FWD_EN
                        ld_rsp_vld_o    = 1'b1;
                        ld_rsp_lq_idx_o = ent_q[i].lq_idx;
                        ld_rsp_data_o   = mem2proc_data_i;
`endif
                    end
                end
            end

            if (req_vld_i && req_rdy_o) begin
                ent_d[alloc_idx].state   = req_is_st_i ? MSHR_WAIT_FILL : MSHR_WAIT_ISS;
                ent_d[alloc_idx].is_st   = req_is_st_i;
                ent_d[alloc_idx].tag     = req_tag_i;
                ent_d[alloc_idx].idx     = req_idx_i;
                ent_d[alloc_idx].data    = req_is_st_i ? req_data_i : 64'd0;
                ent_d[alloc_idx].mem_tag = '0;
                ent_d[alloc_idx].lq_idx  = req_lq_idx_i;
            end
        end
    end

    // Entry table register; reset empties every entry
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MSHR_NUM; i++) ent_q[i] <= '0;
        end else begin
            ent_q <= ent_d;
        end
    end

endmodule

// File: tb/tb_dcache_mshr_ctrl.sv
// tb/tb_dcache_mshr_ctrl.sv - self-checking bench for dcache_mshr_ctrl
module tb_dcache_mshr_ctrl;
    import dcache_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_vld, req_rdy, req_is_st;
    logic [7:0]  req_tag;
    logic [4:0]  req_idx;
    logic [63:0] req_data;
    logic [2:0]  req_lq;
    logic [1:0]  cmd;
    logic [63:0] addr, wdata;
    logic [3:0]  resp, mtag;
    logic [63:0] mdata;
    logic        rsp_en, rsp_dty;
    logic [7:0]  rsp_tag;
    logic [4:0]  rsp_idx;
    logic [63:0] rsp_data;
    logic        iss_en, iss_dty;
    logic [7:0]  iss_tag;
    logic [4:0]  iss_idx;
    logic [63:0] iss_data;
    logic        ev_en;
    logic [4:0]  ev_idx;
    logic [7:0]  ev_tag;
    logic [63:0] ev_data;
    logic        ld_vld;
    logic [2:0]  ld_lq;
    logic [63:0] ld_data;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dcache_mshr_ctrl dut (
        .clk(clk), .rst(rst),
        .req_vld_i(req_vld), .req_rdy_o(req_rdy), .req_is_st_i(req_is_st),
        .req_tag_i(req_tag), .req_idx_i(req_idx), .req_data_i(req_data), .req_lq_idx_i(req_lq),
        .proc2mem_command_o(cmd), .proc2mem_addr_o(addr), .proc2mem_data_o(wdata),
        .mem2proc_response_i(resp), .mem2proc_tag_i(mtag), .mem2proc_data_i(mdata),
        .mshr_rsp_wr_en_o(rsp_en), .mshr_rsp_wr_tag_o(rsp_tag), .mshr_rsp_wr_idx_o(rsp_idx),
        .mshr_rsp_wr_data_o(rsp_data), .mshr_rsp_wr_dty_i(rsp_dty),
        .mshr_iss_st_en_o(iss_en), .mshr_iss_st_tag_o(iss_tag), .mshr_iss_st_idx_o(iss_idx),
        .mshr_iss_st_data_o(iss_data), .mshr_iss_dty_i(iss_dty),
        .mshr_evict_en_o(ev_en), .mshr_evict_idx_o(ev_idx),
        .mshr_evict_tag_i(ev_tag), .mshr_evict_data_i(ev_data),
        .ld_rsp_vld_o(ld_vld), .ld_rsp_lq_idx_o(ld_lq), .ld_rsp_data_o(ld_data)
    );

    typedef struct {
        logic        is_st;
        logic [7:0]  tag;
        logic [4:0]  idx;
        logic [63:0] data;
        logic [2:0]  lq;
        logic [3:0]  mtag;
        logic        dty;
        logic [7:0]  ev_tag;
        logic [63:0] ev_data;
        logic [63:0] exp_ld_addr;
        logic [63:0] exp_st_addr;
    } txn_t;

    typedef struct {
        logic        is_st;
        logic [7:0]  tag;
        logic [4:0]  idx;
        logic [63:0] data;
    } fill_t;

    typedef struct {
        logic [2:0]  lq;
        logic [63:0] data;
    } ld_t;

    fill_t exp_fill[$];
    ld_t   exp_ld[$];
    txn_t  tbl[5];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic st, input logic [7:0] tag, input logic [4:0] idx,
                            input logic [63:0] d, input logic [2:0] lq);
        fill_t f;
        ld_t   l;
        f.is_st = st; f.tag = tag; f.idx = idx; f.data = d;
        exp_fill.push_back(f);
        if (!st) begin
            l.lq = lq; l.data = d;
            exp_ld.push_back(l);
        end
    endtask

    task automatic send(input logic st, input logic [7:0] tag, input logic [4:0] idx,
                        input logic [63:0] d, input logic [2:0] lq, input logic exp_rdy);
        req_vld = 1'b1; req_is_st = st; req_tag = tag; req_idx = idx; req_data = d; req_lq = lq;
        #1 chk("req_rdy", req_rdy, exp_rdy);
        cyc();
        req_vld = 1'b0;
    endtask

    task automatic run_txn(input txn_t t);
        push_exp(t.is_st, t.tag, t.idx, t.data, t.lq);
        send(t.is_st, t.tag, t.idx, t.data, t.lq, 1'b1);
        if (!t.is_st) begin
            #1 chk("iss_cmd", cmd, BUS_LOAD);
            chk("iss_addr", addr, t.exp_ld_addr);
            resp = t.mtag;
            cyc();
            resp = 4'h0;
            #1 chk("wait_mem_cmd", cmd, BUS_NONE);
            mtag = t.mtag; mdata = t.data;
            cyc();
            mtag = 4'h0; mdata = '0;
        end
        if (t.dty) begin
            if (t.is_st) iss_dty = 1'b1; else rsp_dty = 1'b1;
            ev_tag = t.ev_tag; ev_data = t.ev_data;
            #1 chk("wb_cmd", cmd, BUS_STORE);
            chk("wb_addr", addr, t.exp_st_addr);
            chk("wb_data", wdata, t.ev_data);
            chk("wb_refused_quiet", {rsp_en, iss_en, ev_en}, 3'b000);
            cyc();
            #1 chk("wb_retry_cmd", cmd, BUS_STORE);
            resp = 4'h1;
            #1 chk("evict", {ev_en, ev_idx}, {1'b1, t.idx});
            chk("wb_no_fill", {rsp_en, iss_en}, 2'b00);
            cyc();
            resp = 4'h0; rsp_dty = 1'b0; iss_dty = 1'b0; ev_tag = '0; ev_data = '0;
        end
        #1 chk("fill_en", {rsp_en, iss_en}, t.is_st ? 2'b01 : 2'b10);
        chk("fill_bus_idle", cmd, BUS_NONE);
        cyc();
        #1 chk("fill_done", {rsp_en, iss_en}, 2'b00);
        chk("rdy_after", req_rdy, 1'b1);
    endtask

    // Scoreboard: every cache fill and every load completion must match the head of its queue
    always @(negedge clk) begin
        if (!rst) begin
            if (rsp_en || iss_en) begin
                chk("fill_exclusive", {rsp_en, iss_en} == 2'b11, 1'b0);
                if (exp_fill.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL fill_unexpected: rsp_en=%b iss_en=%b at %0t", rsp_en, iss_en, $time);
                end else begin
                    fill_t f;
                    f = exp_fill.pop_front();
                    if (iss_en) chk("fill_rec", {1'b1, iss_tag, iss_idx, iss_data}, {f.is_st, f.tag, f.idx, f.data});
                    else        chk("fill_rec", {1'b0, rsp_tag, rsp_idx, rsp_data}, {f.is_st, f.tag, f.idx, f.data});
                end
            end
            if (ld_vld) begin
                if (exp_ld.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL ld_rsp_unexpected: lq=%0d data=%h at %0t", ld_lq, ld_data, $time);
                end else begin
                    ld_t l;
                    l = exp_ld.pop_front();
                    chk("ld_rsp", {ld_lq, ld_data}, {l.lq, l.data});
                end
            end
        end
    end

    initial begin
        logic [63:0] e_addr [4];
        e_addr[0] = 64'h1010; e_addr[1] = 64'h1110; e_addr[2] = 64'h1210; e_addr[3] = 64'h1310;

        //          is_st tag    idx    data                   lq    mtag  dty   ev_tag ev_data        ld_addr      st_addr
        tbl[0] = '{1'b0, 8'h05, 5'd3,  64'hAA,                3'd1, 4'd2, 1'b0, 8'h00, 64'h0,        64'h518,     64'h0};
        tbl[1] = '{1'b0, 8'h22, 5'd3,  64'h1234,              3'd2, 4'd4, 1'b1, 8'h09, 64'hDEAD,     64'h2218,    64'h918};
        tbl[2] = '{1'b1, 8'h07, 5'd1,  64'hBEEF,              3'd0, 4'd0, 1'b0, 8'h00, 64'h0,        64'h0,       64'h0};
        tbl[3] = '{1'b1, 8'h40, 5'd31, 64'hCAFE,              3'd0, 4'd0, 1'b1, 8'hFF, 64'h55,       64'h0,       64'hFFF8};
        tbl[4] = '{1'b0, 8'hFF, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 3'd7, 4'd15, 1'b0, 8'h00, 64'h0,     64'hFFF8,    64'h0};

        rst = 1'b1; req_vld = 1'b0; req_is_st = 1'b0; req_tag = '0; req_idx = '0; req_data = '0; req_lq = '0;
        resp = '0; mtag = '0; mdata = '0; rsp_dty = 1'b0; iss_dty = 1'b0; ev_tag = '0; ev_data = '0;
        repeat (2) cyc();
        rst = 1'b0;
        #1 chk("reset_rdy", req_rdy, 1'b1);
        chk("reset_bus", {cmd, addr, wdata}, '0);
        chk("reset_en", {rsp_en, iss_en, ev_en, ld_vld}, 4'b0000);
        cyc();

        for (int i = 0; i < 5; i++) run_txn(tbl[i]);

        // Fill all four entries, with a secondary miss stalled in the middle
        send(1'b0, 8'h10, 5'd2, '0, 3'd0, 1'b1);
        send(1'b0, 8'h11, 5'd2, '0, 3'd1, 1'b1);
        send(1'b0, 8'h12, 5'd2, '0, 3'd2, 1'b1);
        send(1'b0, 8'h10, 5'd2, '0, 3'd5, 1'b0);
        send(1'b0, 8'h13, 5'd2, '0, 3'd3, 1'b1);
        req_tag = 8'h77;
        #1 chk("full_rdy", req_rdy, 1'b0);
        cyc();

        // Memory refuses three times, then takes the head load
        for (int i = 0; i < 3; i++) begin
            #1 chk("refused_cmd", {cmd, addr}, {BUS_LOAD, e_addr[0]});
            cyc();
        end
        #1 chk("accept_cmd", {cmd, addr}, {BUS_LOAD, e_addr[0]});
        resp = 4'd3; cyc();
        #1 chk("iss_e1", {cmd, addr}, {BUS_LOAD, e_addr[1]});
        resp = 4'd1; cyc();
        #1 chk("iss_e2", {cmd, addr}, {BUS_LOAD, e_addr[2]});
        resp = 4'd5; cyc();
        #1 chk("iss_e3", {cmd, addr}, {BUS_LOAD, e_addr[3]});
        resp = 4'd6; cyc();
        resp = 4'd0;
        #1 chk("all_issued", cmd, BUS_NONE);

        // Unknown tag is dropped
        mtag = 4'd9; mdata = 64'h999;
        cyc();
        #1 chk("drop_unknown", {rsp_en, ld_vld}, 2'b00);

        // Out-of-order completion: tag 1 (entry 1) then tag 3 (entry 0)
        push_exp(1'b0, 8'h11, 5'd2, 64'hD1, 3'd1);
        push_exp(1'b0, 8'h10, 5'd2, 64'hD0, 3'd0);
        mtag = 4'd1; mdata = 64'hD1;
        cyc();
        mtag = 4'd3; mdata = 64'hD0;
        #1 chk("ooo_fill1", {rsp_en, rsp_tag}, {1'b1, 8'h11});
        cyc();
        mtag = 4'd0; mdata = '0;
        #1 chk("ooo_fill0", {rsp_en, rsp_tag}, {1'b1, 8'h10});
        cyc();
        #1 chk("ooo_done", rsp_en, 1'b0);

        // Reset with entries 2 and 3 waiting on memory tags 5 and 6
        rst = 1'b1; mtag = 4'd5; mdata = 64'h55AA;
        #1 chk("rst_bus", {cmd, addr, wdata}, '0);
        chk("rst_en", {rsp_en, iss_en, ev_en, ld_vld}, 4'b0000);
        chk("rst_ports", {rsp_tag, rsp_idx, iss_tag, iss_idx, ev_idx}, '0);
        cyc();
        rst = 1'b0; mtag = 4'd6; mdata = 64'h66BB;
        #1 chk("stale_drop", ld_vld, 1'b0);
        chk("post_rst_rdy", req_rdy, 1'b1);
        cyc();
        mtag = 4'd0; mdata = '0;
        #1 chk("stale_no_fill", {rsp_en, cmd}, 3'b000);
        cyc();
        #1 chk("stale_no_fill2", {rsp_en, cmd}, 3'b000);

        chk("sb_fill_drained", exp_fill.size(), 0);
        chk("sb_ld_drained", exp_ld.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
